// File: rtl/airlock_pkg.sv
// rtl/airlock_pkg.sv - state encoding, direction constants and output decode for the airlock sequencer
package airlock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLOSE_WAIT,
      ST_SETTLE,
      ST_PUMP,
      ST_UNLOCK,
      ST_FAULT
   } state_t;

   localparam logic DIR_ARRIVE = 1'b0;
   localparam logic DIR_DEPART = 1'b1;

   localparam int DEF_CNT_W          = 16;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_PUMP_CYCLES    = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1000;

   typedef struct packed {
      logic busy;
      logic press;
      logic depress;
      logic id_unlock;
      logic od_unlock;
      logic fault;
   } outs_t;

   // Moore decode of the state being entered; dir selects which pump and which door is driven.
   function automatic outs_t state_outs(state_t s, logic dir);
      outs_t o;
      o.busy      = (s != ST_IDLE);
      o.press     = (s == ST_PUMP)   && (dir == DIR_ARRIVE);
      o.depress   = (s == ST_PUMP)   && (dir == DIR_DEPART);
      o.id_unlock = (s == ST_UNLOCK) && (dir == DIR_ARRIVE);
      o.od_unlock = (s == ST_UNLOCK) && (dir == DIR_DEPART);
      o.fault     = (s == ST_FAULT);
      return o;
   endfunction

endpackage

// File: rtl/airlock_timer.sv
// rtl/airlock_timer.sv - clearable up-counter that saturates at limit, with a terminal compare
module airlock_timer
   import airlock_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (count < limit) begin
         count <= count + 1'b1;
      end
   end

   // The cycle in progress is included, so a limit of N fires on the edge ending the Nth cycle after clear.
   assign hit = (count >= limit - 1'b1);

endmodule

// File: rtl/airlock_cycle_controller.sv
// rtl/airlock_cycle_controller.sv - arrival/departure airlock sequencer
// AIRLOCK_TIMEOUT_EN adds a watchdog that faults a stalled CLOSE_WAIT or PUMP.
module airlock_cycle_controller
   import airlock_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int PUMP_CYCLES    = DEF_PUMP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic direction,
   input  logic odClosed,
   input  logic idClosed,
   input  logic isHighPressure,
   input  logic ack,
   output logic busy,
   output logic startPressurizing,
   output logic startDepressurizing,
   output logic idUnlock,
   output logic odUnlock,
   output logic done,
   output logic fault
);

   localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] PUMP_LIM   = CNT_W'(PUMP_CYCLES);

   state_t           state;
   logic             dir;
   outs_t            outs;
   logic             both_closed;
   logic             target_closed;
   logic             other_closed;
   logic             cnt_clr;
   logic             cnt_hit;
   logic [CNT_W-1:0] cnt_limit;
   logic             wd_timeout;

   assign both_closed   = odClosed & idClosed;
   assign target_closed = (dir == DIR_DEPART) ? odClosed : idClosed;
   assign other_closed  = (dir == DIR_DEPART) ? idClosed : odClosed;

   // Shared timer: free-runs only in SETTLE and PUMP, restarts on the SETTLE->PUMP hand-off.
   assign cnt_clr   = (state == ST_SETTLE) ? cnt_hit : (state != ST_PUMP);
   assign cnt_limit = (state == ST_PUMP) ? PUMP_LIM : SETTLE_LIM;

   airlock_timer #(.CNT_W(CNT_W)) u_cycle_timer (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .limit (cnt_limit),
      .hit   (cnt_hit)
   );

`ifdef AIRLOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
   logic wd_clr;

   assign wd_clr = (state != ST_CLOSE_WAIT) && (state != ST_PUMP);

   airlock_timer #(.CNT_W(CNT_W)) u_watchdog (
      .clock (clock),
      .reset (reset),
      .clr   (wd_clr),
      .limit (TIMEOUT_LIM),
      .hit   (wd_timeout)
   );
`else
   assign wd_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         dir   <= DIR_ARRIVE;
         outs  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  dir   <= direction;
                  state <= ST_CLOSE_WAIT;
                  outs  <= state_outs(ST_CLOSE_WAIT, direction);
               end
            end
            ST_CLOSE_WAIT: begin
               if (wd_timeout) begin
                  state <= ST_FAULT;
                  outs  <= state_outs(ST_FAULT, dir);
               end else if (both_closed) begin
                  state <= ST_SETTLE;
                  outs  <= state_outs(ST_SETTLE, dir);
               end
            end
            ST_SETTLE: begin
               if (!both_closed) begin
                  state <= ST_CLOSE_WAIT;
                  outs  <= state_outs(ST_CLOSE_WAIT, dir);
               end else if (cnt_hit) begin
                  state <= ST_PUMP;
                  outs  <= state_outs(ST_PUMP, dir);
               end
            end
            ST_PUMP: begin
               // A door opening under pump outranks a normal exit on the same edge.
               if (!both_closed || wd_timeout) begin
                  state <= ST_FAULT;
                  outs  <= state_outs(ST_FAULT, dir);
               end else if (cnt_hit && (isHighPressure == ~dir)) begin
                  state <= ST_UNLOCK;
                  outs  <= state_outs(ST_UNLOCK, dir);
               end
            end
            ST_UNLOCK: begin
               if (!other_closed) begin
                  state <= ST_FAULT;
                  outs  <= state_outs(ST_FAULT, dir);
               end else if (!target_closed) begin
                  state <= ST_IDLE;
                  outs  <= state_outs(ST_IDLE, dir);
                  done  <= 1'b1;
               end
            end
            ST_FAULT: begin
               if (ack) begin
                  state <= ST_IDLE;
                  outs  <= state_outs(ST_IDLE, dir);
               end
            end
            default: begin
               state <= ST_IDLE;
               outs  <= '0;
            end
         endcase
      end
   end

   assign busy                = outs.busy;
   assign startPressurizing   = outs.press;
   assign startDepressurizing = outs.depress;
   assign idUnlock            = outs.id_unlock;
   assign odUnlock            = outs.od_unlock;
   assign fault               = outs.fault;

endmodule
